io_event_capture: RTL and testbench

IO_EVENT_CAPTURE -- requirements
Module: io_event_capture

---
 rtl/io_event_capture_pkg.sv | 11 +
 rtl/io_event_fifo.sv | 63 ++++++
 rtl/io_event_capture.sv | 114 +++++++++++
 tb/tb_io_event_capture.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_event_capture_pkg.sv
// Shared constants and helpers for the io event capture block.
package io_event_capture_pkg;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TS_WIDTH   = 16;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_event_fifo.sv
// First-word-fall-through synchronous event buffer with occupancy count.
module io_event_fifo
    import io_event_capture_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DW-1:0]           din,
    input  logic                    pop,
    output logic [DW-1:0]           dout,
    output logic                    full,
    output logic                    empty,
    output logic [lvl_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full buffer still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_event_capture.sv
// Timestamped edge capture on an io bundle, buffered for a valid/ready consumer.
// Optional input synchronizer: define IO_EVENT_CAPTURE_SYNC_EN.
module io_event_capture
    import io_event_capture_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             io,
    input  logic                         enable,
    input  logic [WIDTH-1:0]             rise_mask,
    input  logic [WIDTH-1:0]             fall_mask,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic [WIDTH-1:0]             ev_io,
    output logic [WIDTH-1:0]             ev_changed,
    output logic [TS_WIDTH-1:0]          ev_ts,
    output logic                         overflow,
    input  logic                         overflow_clr,
    output logic [lvl_w(FIFO_DEPTH)-1:0] level
);

    localparam int DW = 2 * WIDTH + TS_WIDTH;

    logic [WIDTH-1:0]    io_src;
    logic                src_ok;
    logic [WIDTH-1:0]    io_q;
    logic [WIDTH-1:0]    io_prev;
    logic                io_q_ok;
    logic                prime;
    logic [WIDTH-1:0]    changed;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic                push_req;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;
    logic [DW-1:0]       head;

`ifdef IO_EVENT_CAPTURE_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [1:0]       sync_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            sync_ok <= '0;
        end else begin
            sync1   <= io;
            sync2   <= sync1;
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    assign io_src = sync2;
    assign src_ok = sync_ok[1];
`else
    assign io_src = io;
    assign src_ok = 1'b1;
`endif

    // prime rises only once io_prev holds a real sample, not its reset value
    always_ff @(posedge clk) begin
        if (reset) begin
            io_q     <= '0;
            io_prev  <= '0;
            io_q_ok  <= 1'b0;
            prime    <= 1'b0;
            ts_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            io_q    <= io_src;
            io_prev <= io_q;
            io_q_ok <= src_ok;
            prime   <= io_q_ok;
            ts_cnt  <= ts_cnt + TS_WIDTH'(1);
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign changed  = (io_q ^ io_prev)
                    & ((io_q & rise_mask) | (~io_q & fall_mask));
    assign push_req = enable & prime & (|changed);
    assign pop      = ev_valid & ev_ready;
    assign drop     = push_req & full & ~pop;
    assign ev_valid = ~empty;

    io_event_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   ({io_q, changed, ts_cnt}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign {ev_io, ev_changed, ev_ts} = head;

endmodule

// File: tb/tb_io_event_capture.sv
// Scoreboard bench for io_event_capture (WIDTH=4, FIFO_DEPTH=4, TS_WIDTH=8).
module tb_io_event_capture;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int TW = 8;

    typedef struct packed {
        logic [W-1:0]  io;
        logic [W-1:0]  ch;
        logic [TW-1:0] ts;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  io = '0;
    logic          enable = 1'b0;
    logic [W-1:0]  rise_mask = '0;
    logic [W-1:0]  fall_mask = '0;
    logic          ev_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          ev_valid;
    logic [W-1:0]  ev_io;
    logic [W-1:0]  ev_changed;
    logic [TW-1:0] ev_ts;
    logic          overflow;
    logic [2:0]    level;

    ev_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] io_m = '0;

    io_event_capture #(
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .TS_WIDTH   (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io           (io),
        .enable       (enable),
        .rise_mask    (rise_mask),
        .fall_mask    (fall_mask),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_io        (ev_io),
        .ev_changed   (ev_changed),
        .ev_ts        (ev_ts),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .level        (level)
    );

    always #5 clk = ~clk;

    // cycle index of the last edge since reset release
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ev_t e;
        if (!reset && ev_valid && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard unexpected event io=%h ch=%h ts=%0d",
                         ev_io, ev_changed, ev_ts);
            end else begin
                e = exp_q.pop_front();
                if ({ev_io, ev_changed, ev_ts} !== e) begin
                    errors++;
                    $display("FAIL scoreboard got io=%h ch=%h ts=%0d required io=%h ch=%h ts=%0d",
                             ev_io, ev_changed, ev_ts, e.io, e.ch, e.ts);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_io(input logic [W-1:0] v, input bit force_acc);
        logic [W-1:0] ch;
        ev_t e;
        ch = (v ^ io_m) & ((v & rise_mask) | (~v & fall_mask));
        if (enable && ch != '0 && (exp_q.size() < D || force_acc)) begin
            e.io = v;
            e.ch = ch;
            e.ts = TW'(cyc + 1);
            exp_q.push_back(e);
        end
        io   = v;
        io_m = v;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if (ev_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b lvl=%0d ovf=%b required 0 0 0",
                     ev_valid, level, overflow);
        end
        checks++;
        if ({ev_io, ev_changed, ev_ts} !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h required 0", {ev_io, ev_changed, ev_ts});
        end
        reset = 1'b0;
    endtask

    task automatic test_rise();
        enable    = 1'b1;
        rise_mask = 4'hF;
        fall_mask = 4'h0;
        tick(9);
        set_io(4'h5, 1'b0);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_latency got ev_valid=%b at edge 10 required 0", ev_valid);
        end
        tick(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_io !== 4'h5 || ev_changed !== 4'h5 || ev_ts !== 8'd10) begin
            errors++;
            $display("FAIL rise_event got v=%b io=%h ch=%h ts=%0d required 1 5 5 10",
                     ev_valid, ev_io, ev_changed, ev_ts);
        end
        tick(2);
        checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 8'd10 || level !== 3'd1) begin
            errors++;
            $display("FAIL rise_hold got v=%b ts=%0d lvl=%0d required 1 10 1",
                     ev_valid, ev_ts, level);
        end
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        rise_mask = 4'h0;
        set_io(4'h0, 1'b0);
        tick(3);
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL rise_masked_fall got lvl=%0d v=%b required 0 0", level, ev_valid);
        end
    endtask

    task automatic test_fall();
        fall_mask = 4'h1;
        set_io(4'h1, 1'b0);
        set_io(4'h0, 1'b0);
        tick(2);
        checks++;
        if (level !== 3'd1 || ev_changed !== 4'h1 || ev_io !== 4'h0) begin
            errors++;
            $display("FAIL fall_event got lvl=%0d ch=%h io=%h required 1 1 0",
                     level, ev_changed, ev_io);
        end
        ev_ready = 1'b1;
        tick(2);
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL fall_drain got lvl=%0d required 0", level);
        end
    endtask

    task automatic test_overflow();
        rise_mask = 4'hF;
        fall_mask = 4'hF;
        for (int i = 0; i < 6; i++) begin
            set_io((i % 2 == 0) ? 4'h1 : 4'h0, 1'b0);
        end
        tick(3);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full got lvl=%0d ovf=%b required 4 1", level, overflow);
        end
        ev_ready = 1'b1;
        tick(6);
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || overflow !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain got lvl=%0d ovf=%b left=%0d required 0 1 0",
                     level, overflow, exp_q.size());
        end
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_io((i % 2 == 0) ? 4'h1 : 4'h0, 1'b0);
        end
        tick(3);
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL b2b_fill got lvl=%0d required 4", level);
        end
        set_io(4'h3, 1'b1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_swap got lvl=%0d ovf=%b required 4 0", level, overflow);
        end
        ev_ready = 1'b1;
        tick(6);
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got lvl=%0d left=%0d required 0 0", level, exp_q.size());
        end
    endtask

    task automatic test_ts_wrap();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        io_m = io;
        tick(299);
        set_io(4'h7, 1'b0);
        tick(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_ts !== 8'd44 || ev_changed !== 4'h4) begin
            errors++;
            $display("FAIL ts_wrap got v=%b ts=%0d ch=%h required 1 44 4",
                     ev_valid, ev_ts, ev_changed);
        end
        set_io(4'h3, 1'b0);
        set_io(4'h7, 1'b0);
        tick(2);
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL ts_level got lvl=%0d required 3", level);
        end
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got lvl=%0d v=%b ovf=%b required 0 0 0",
                     level, ev_valid, overflow);
        end
        reset = 1'b0;
        io_m = io;
        tick(10);
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got lvl=%0d v=%b required 0 0", level, ev_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_overflow();
        test_back_to_back();
        test_ts_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
